// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer driving datapath controls, PC and IR
module control_unit #(
    parameter logic [3:0] FS_PASS_A = 4'hA,
    parameter logic [3:0] FS_PASS_B = 4'hB
) (
    input  logic        clk_main,
    input  logic        reset,
    input  logic [15:0] MemData,
    input  logic        Z,
    output logic [5:0]  PC,
    output logic [3:0]  DR,
    output logic [3:0]  SA,
    output logic [3:0]  SB,
    output logic [3:0]  FS,
    output logic        MB,
    output logic        MM,
    output logic        MD,
    output logic        RW,
    output logic        MW,
    output logic        halted
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, LOAD_WB, HALT} stateType;
    stateType state, nextState;
    logic [15:0] ir;
    logic [3:0] op, d, a, b;
    assign op = ir[15:12];
    assign d = ir[11:8];
    assign a = ir[7:4];
    assign b = ir[3:0];
    assign halted = state == HALT;
    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            PC <= 6'd0;
            ir <= 16'd0;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                ir <= MemData;
                PC <= PC + 6'd1;
            end else if (state == EXEC && (op == 4'hE || (op == 4'hD && Z))) begin
                PC <= ir[5:0];
            end
        end
    end
    always_comb begin
        nextState = state == FETCH   ? DECODE :
                    state == DECODE  ? EXEC :
                    state == EXEC    ? (op == 4'hB ? LOAD_WB : op == 4'hF ? HALT : FETCH) :
                    state == LOAD_WB ? FETCH : HALT;
    end
    // Strobes are additionally gated by reset so they drop the instant reset falls
    always_comb begin
        DR = 4'd0;
        SA = 4'd0;
        SB = 4'd0;
        FS = 4'd0;
        MB = 1'b0;
        MM = 1'b1;
        MD = 1'b0;
        RW = 1'b0;
        MW = 1'b0;
        if (state == EXEC) begin
            if (op <= 4'h9) begin
                FS = op;
                DR = d;
                SA = a;
                SB = b;
                RW = 1'b1;
            end else if (op == 4'hA) begin
                DR = d;
                MB = 1'b1;
                FS = FS_PASS_B;
                RW = 1'b1;
            end else if (op == 4'hB) begin
                SA = a;
                MM = 1'b0;
            end else if (op == 4'hC) begin
                SA = a;
                SB = b;
                FS = FS_PASS_B;
                MM = 1'b0;
                MW = 1'b1;
            end else if (op == 4'hD) begin
                SA = d;
                FS = FS_PASS_A;
            end
        end else if (state == LOAD_WB) begin
            DR = d;
            SA = a;
            MD = 1'b1;
            MM = 1'b0;
            RW = 1'b1;
        end
        if (!reset) begin
            RW = 1'b0;
            MW = 1'b0;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scenario tests for control_unit with a synchronous-read memory model
module tb_control_unit;
    logic clk_main = 1'b0;
    logic reset = 1'b0;
    logic [15:0] MemData = 16'd0;
    logic Z = 1'b0;
    logic [5:0] PC;
    logic [3:0] DR, SA, SB, FS;
    logic MB, MM, MD, RW, MW, halted;
    logic [15:0] mem [64];
    logic [20:0] ctl;
    int compared = 0;
    int mismatched = 0;
    localparam logic [20:0] FETCH_CTL = {4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    control_unit dut (
        .clk_main(clk_main), .reset(reset), .MemData(MemData), .Z(Z), .PC(PC),
        .DR(DR), .SA(SA), .SB(SB), .FS(FS), .MB(MB), .MM(MM), .MD(MD), .RW(RW), .MW(MW),
        .halted(halted)
    );

    always #5 clk_main = ~clk_main;
    always @(posedge clk_main) MemData <= mem[PC];
    assign ctl = {DR, SA, SB, FS, MB, MM, MD, RW, MW};

    task tick(input int n);
        repeat (n) @(negedge clk_main);
    endtask

    task clearMem;
        for (int i = 0; i < 64; i++) mem[i] = 16'hF000;
    endtask

    task start;
        reset = 1'b0;
        @(negedge clk_main);
        reset = 1'b1;
    endtask

    task test_reset;
        clearMem();
        @(negedge clk_main);
        compared++;
        if (ctl !== FETCH_CTL || PC !== 6'd0 || halted !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: ctl=%h pc=%0d halted=%b, want ctl=%h pc=0 halted=0", ctl, PC, halted, FETCH_CTL);
        end
    endtask

    task test_ldi;
        clearMem();
        mem[0] = 16'hA15A;
        start();
        compared++;
        if (ctl !== FETCH_CTL) begin mismatched++; $display("FAIL ldi_fetch: ctl=%h want %h", ctl, FETCH_CTL); end
        tick(1);
        compared++;
        if (ctl !== FETCH_CTL) begin mismatched++; $display("FAIL ldi_decode: ctl=%h want %h", ctl, FETCH_CTL); end
        tick(1);
        compared++;
        if (ctl !== {4'd1, 4'd0, 4'd0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0} || PC !== 6'd1) begin
            mismatched++;
            $display("FAIL ldi_exec: ctl=%h pc=%0d want ctl=%h pc=1", ctl, PC, {4'd1, 4'd0, 4'd0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        tick(1);
        compared++;
        if (ctl !== FETCH_CTL || PC !== 6'd1) begin mismatched++; $display("FAIL ldi_next_fetch: ctl=%h pc=%0d want ctl=%h pc=1", ctl, PC, FETCH_CTL); end
    endtask

    task test_back_to_back;
        clearMem();
        mem[0] = 16'hA103;
        mem[1] = 16'hA204;
        mem[2] = 16'h2312;
        start();
        tick(8);
        compared++;
        if (ctl !== {4'd3, 4'd1, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL alu_exec: ctl=%h want %h", ctl, {4'd3, 4'd1, 4'd2, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        tick(1);
        compared++;
        if (PC !== 6'd3 || ctl !== FETCH_CTL) begin mismatched++; $display("FAIL alu_pc: pc=%0d ctl=%h want pc=3 ctl=%h", PC, ctl, FETCH_CTL); end
    endtask

    task test_ld_st;
        clearMem();
        mem[0] = 16'hB410;
        mem[1] = 16'hC561;
        start();
        tick(2);
        compared++;
        if (ctl !== {4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL ld_exec: ctl=%h want %h", ctl, {4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        tick(1);
        compared++;
        if (ctl !== {4'd4, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL ld_wb: ctl=%h want %h", ctl, {4'd4, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        tick(1);
        compared++;
        if (ctl !== FETCH_CTL || PC !== 6'd1) begin mismatched++; $display("FAIL ld_latency: ctl=%h pc=%0d want ctl=%h pc=1", ctl, PC, FETCH_CTL); end
        tick(1);
        compared++;
        if (MW !== 1'b0) begin mismatched++; $display("FAIL st_decode_mw: mw=%b want 0", MW); end
        tick(1);
        compared++;
        if (ctl !== {4'd0, 4'd6, 4'd1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL st_exec: ctl=%h want %h", ctl, {4'd0, 4'd6, 4'd1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        tick(1);
        compared++;
        if (MW !== 1'b0 || PC !== 6'd2) begin mismatched++; $display("FAIL st_after: mw=%b pc=%0d want mw=0 pc=2", MW, PC); end
    endtask

    task test_branch;
        clearMem();
        mem[0] = 16'hD127;
        Z = 1'b1;
        start();
        tick(2);
        compared++;
        if (ctl !== {4'd0, 4'd1, 4'd0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL bz_exec: ctl=%h want %h", ctl, {4'd0, 4'd1, 4'd0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        tick(1);
        compared++;
        if (PC !== 6'h27) begin mismatched++; $display("FAIL bz_taken: pc=%h want 27", PC); end
        Z = 1'b0;
        start();
        tick(3);
        compared++;
        if (PC !== 6'd1) begin mismatched++; $display("FAIL bz_not_taken: pc=%0d want 1", PC); end
        clearMem();
        mem[0] = 16'hE03F;
        mem[63] = 16'hA77F;
        start();
        tick(3);
        compared++;
        if (PC !== 6'd63) begin mismatched++; $display("FAIL jmp: pc=%0d want 63", PC); end
        tick(2);
        compared++;
        if (PC !== 6'd0 || ctl !== {4'd7, 4'd0, 4'd0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL jmp_wrap: pc=%0d ctl=%h want pc=0 ctl=%h", PC, ctl, {4'd7, 4'd0, 4'd0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task test_halt;
        clearMem();
        start();
        tick(2);
        compared++;
        if (ctl !== FETCH_CTL || halted !== 1'b0) begin mismatched++; $display("FAIL halt_exec: ctl=%h halted=%b want ctl=%h halted=0", ctl, halted, FETCH_CTL); end
        for (int i = 0; i < 22; i++) begin
            tick(1);
            compared++;
            if (halted !== 1'b1 || RW !== 1'b0 || MW !== 1'b0 || PC !== 6'd1) begin
                mismatched++;
                $display("FAIL halt_hold[%0d]: halted=%b rw=%b mw=%b pc=%0d want 1 0 0 1", i, halted, RW, MW, PC);
            end
        end
        mem[0] = 16'hA15A;
        reset = 1'b0;
        #1;
        compared++;
        if (halted !== 1'b0 || PC !== 6'd0 || ctl !== FETCH_CTL) begin mismatched++; $display("FAIL halt_reset: halted=%b pc=%0d ctl=%h want 0 0 %h", halted, PC, ctl, FETCH_CTL); end
        @(negedge clk_main);
        reset = 1'b1;
        tick(2);
        compared++;
        if (ctl !== {4'd1, 4'd0, 4'd0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0} || PC !== 6'd1) begin
            mismatched++;
            $display("FAIL halt_restart: ctl=%h pc=%0d want ctl=%h pc=1", ctl, PC, {4'd1, 4'd0, 4'd0, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task test_abort;
        clearMem();
        mem[0] = 16'hB410;
        start();
        tick(3);
        compared++;
        if (RW !== 1'b1 || MD !== 1'b1) begin mismatched++; $display("FAIL abort_pre: rw=%b md=%b want 1 1", RW, MD); end
        reset = 1'b0;
        #1;
        compared++;
        if (RW !== 1'b0 || PC !== 6'd0 || ctl !== FETCH_CTL) begin mismatched++; $display("FAIL abort_now: rw=%b pc=%0d ctl=%h want 0 0 %h", RW, PC, ctl, FETCH_CTL); end
        @(posedge clk_main);
        #1;
        compared++;
        if (RW !== 1'b0 || MW !== 1'b0 || PC !== 6'd0) begin mismatched++; $display("FAIL abort_edge: rw=%b mw=%b pc=%0d want 0 0 0", RW, MW, PC); end
        @(negedge clk_main);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_back_to_back();
        test_ld_st();
        test_branch();
        test_halt();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
